cmos_capture_ctrl: RTL and testbench



---
 rtl/cmos_capture_ctrl_pkg.sv | 47 ++++
 rtl/cmos_capture_ctrl_if.sv | 21 ++
 rtl/cmos_capture_ctrl_dvp_byte_pack.sv | 70 +++++++
 rtl/cmos_capture_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_cmos_capture_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cmos_capture_ctrl_pkg.sv
// Shared camera/VGA definitions for the capture path.
// Contents: default frame geometry, RGB565 colour constants, FSM state
// encodings, the registered DVP sample payload and a colour-bar lookup.
package cmos_capture_ctrl_pkg;

    localparam int unsigned H_SIZE_DEF = 640;
    localparam int unsigned V_SIZE_DEF = 480;

    localparam logic [15:0] RGB_BLACK   = 16'h0000;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_ROYAL   = 16'h435C;

    typedef enum logic [1:0] {
        ST_SKIP    = 2'd0,
        ST_WAIT_FS = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic       vsync;
        logic       href;
        logic [7:0] data;
    } dvp_sample_t;

    // Eight vertical stripes, left to right.
    function automatic logic [15:0] colour_bar(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_ROYAL;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cmos_capture_ctrl_if.sv
// Camera-side bus of the capture controller: DVP pins in, FIFO write port out.
// master: the capture controller (drives cam_w_req/cam_w_data).
// slave : sensor + write FIFO (drive cmos_* and w_fifo_usedw).
interface cmos_capture_ctrl_if;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;
    logic [10:0] w_fifo_usedw;
    logic        cam_w_req;
    logic [15:0] cam_w_data;

    modport master (
        input  cmos_vsync, cmos_href, cmos_data, w_fifo_usedw,
        output cam_w_req, cam_w_data
    );

    modport slave (
        output cmos_vsync, cmos_href, cmos_data, w_fifo_usedw,
        input  cam_w_req, cam_w_data
    );
endinterface

// File: rtl/cmos_capture_ctrl_dvp_byte_pack.sv
// DVP front end: registers the pins once (s1), keeps a second vsync/href
// stage (s2) for edge detection and pairs bytes into 16-bit words.
// Ports:
//   clk, rst        pixel clock, async active-high reset
//   en_i            byte pairing enabled (controller is capturing)
//   vsync_i/href_i/data_i  raw DVP pins
//   fs_c/fe_c/le_c  frame start, frame end, line end events
//   word_valid_c    a word completes this cycle; word_c carries it
//   phase_o         a high byte is held waiting for its partner
module cmos_capture_ctrl_dvp_byte_pack
    import cmos_capture_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        vsync_i,
    input  logic        href_i,
    input  logic [7:0]  data_i,
    output logic        fs_c,
    output logic        fe_c,
    output logic        le_c,
    output logic        word_valid_c,
    output logic [15:0] word_c,
    output logic        phase_o
);

    dvp_sample_t s1_q;
    logic        vsync_s2_q;
    logic        href_s2_q;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;

    // vsync stages reset high (blanking) so a sensor already in blanking
    // does not produce a false frame end at reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '{vsync: 1'b1, href: 1'b0, data: 8'h00};
            vsync_s2_q <= 1'b1;
            href_s2_q  <= 1'b0;
            phase_q    <= 1'b0;
            hi_q       <= 8'h00;
        end else begin
            s1_q       <= '{vsync: vsync_i, href: href_i, data: data_i};
            vsync_s2_q <= s1_q.vsync;
            href_s2_q  <= s1_q.href;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
        end
    end

    // Phase toggles per valid byte; any href-low cycle drops a dangling byte.
    always_comb begin
        phase_d = 1'b0;
        hi_d    = hi_q;
        if (en_i && s1_q.href) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = s1_q.data;
            end
        end
    end

    assign fs_c         = vsync_s2_q & ~s1_q.vsync;
    assign fe_c         = ~vsync_s2_q & s1_q.vsync;
    assign le_c         = href_s2_q & ~s1_q.href;
    assign word_valid_c = en_i & s1_q.href & phase_q;
    assign word_c       = {hi_q, s1_q.data};
    assign phase_o      = phase_q;

endmodule

// File: rtl/cmos_capture_ctrl.sv
// OV7670 capture controller: frame-aligned RGB565 writer into the SDRAM
// write FIFO. Skips settle frames after reset, checks line/frame geometry,
// drops words when the FIFO is near full.
// Ports:
//   clk, rst       camera PCLK, async active-high reset
//   capture_en     capture enable, sampled at frame start
//   bus            cmos_* pins, w_fifo_usedw in; cam_w_req/cam_w_data out
//   frame_done     one-cycle pulse for a frame with correct geometry
//   frame_err      sticky: last captured frame had wrong geometry
//   overflow       sticky: a word was dropped during this frame
//   frame_cnt      captured-frame counter (wraps)
// Build option: CMOS_CAPTURE_TEST_PATTERN_EN replaces pixel data with an
// 8-stripe colour bar; timing and drop rules are unchanged.
module cmos_capture_ctrl
    import cmos_capture_ctrl_pkg::*;
#(
    parameter int unsigned H_SIZE      = H_SIZE_DEF,
    parameter int unsigned V_SIZE      = V_SIZE_DEF,
    parameter int unsigned SKIP_FRAMES = 10,
    parameter int unsigned FIFO_DEPTH  = 1024,
    parameter int unsigned FIFO_MARGIN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      capture_en,
    cmos_capture_ctrl_if.master       bus,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      overflow,
    output logic [7:0]                frame_cnt
);

    // Counters saturate one past nominal so overruns stay visible.
    localparam int unsigned PIX_W  = $clog2(H_SIZE + 2);
    localparam int unsigned LINE_W = $clog2(V_SIZE + 2);
    localparam int unsigned SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [PIX_W-1:0]  PIX_MAX  = PIX_W'(H_SIZE + 1);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_SIZE + 1);
    localparam logic [10:0]       FULL_LVL = 11'(FIFO_DEPTH - FIFO_MARGIN);

    cap_state_e          state_q, state_d;
    logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic                geom_err_q, geom_err_d;
    logic                overflow_q, overflow_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                w_req_q, w_req_d;
    logic [15:0]         w_data_q, w_data_d;

    logic                capturing_c;
    logic                fs_c, fe_c, le_c;
    logic                word_valid_c;
    logic [15:0]         word_c;
    logic                phase;
    logic [15:0]         pix_word_c;
    logic                fifo_full_c;

    assign capturing_c = (state_q == ST_CAPTURE);
    assign fifo_full_c = (bus.w_fifo_usedw >= FULL_LVL);

    cmos_capture_ctrl_dvp_byte_pack u_pack (
        .clk          (clk),
        .rst          (rst),
        .en_i         (capturing_c),
        .vsync_i      (bus.cmos_vsync),
        .href_i       (bus.cmos_href),
        .data_i       (bus.cmos_data),
        .fs_c         (fs_c),
        .fe_c         (fe_c),
        .le_c         (le_c),
        .word_valid_c (word_valid_c),
        .word_c       (word_c),
        .phase_o      (phase)
    );

`ifdef CMOS_CAPTURE_TEST_PATTERN_EN
    localparam int unsigned STRIPE_W = (H_SIZE / 8 > 0) ? H_SIZE / 8 : 1;
    logic [31:0] stripe_c;

    // Stripe index from the in-line pixel position, clamped to the last bar.
    always_comb begin
        stripe_c   = 32'(pix_cnt_q) / 32'(STRIPE_W);
        pix_word_c = colour_bar((stripe_c > 32'd7) ? 3'd7 : stripe_c[2:0]);
    end
`else
    assign pix_word_c = word_c;
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SKIP;
            skip_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            geom_err_q   <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= 8'h00;
            w_req_q      <= 1'b0;
            w_data_q     <= 16'h0000;
        end else begin
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            geom_err_q   <= geom_err_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
            w_req_q      <= w_req_d;
            w_data_q     <= w_data_d;
        end
    end

    // Next-state, counters and FIFO gating.
    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        geom_err_d   = geom_err_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;
        frame_cnt_d  = frame_cnt_q;
        w_req_d      = 1'b0;
        w_data_d     = w_data_q;

        case (state_q)
            ST_SKIP: begin
                if (SKIP_FRAMES == 0) begin
                    state_d = ST_WAIT_FS;
                end else if (fe_c) begin
                    if (skip_cnt_q == SKIP_W'(SKIP_FRAMES - 1)) begin
                        state_d = ST_WAIT_FS;
                    end else begin
                        skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                    end
                end
            end

            ST_WAIT_FS: begin
                if (fs_c && capture_en) begin
                    state_d    = ST_CAPTURE;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    geom_err_d = 1'b0;
                    overflow_d = 1'b0;
                end
            end

            ST_CAPTURE: begin
                // Out-of-geometry words are counted but never written.
                if (word_valid_c) begin
                    if (pix_cnt_q < PIX_W'(H_SIZE) && line_cnt_q < LINE_W'(V_SIZE)) begin
                        if (fifo_full_c) begin
                            overflow_d = 1'b1;
                        end else begin
                            w_req_d  = 1'b1;
                            w_data_d = pix_word_c;
                        end
                    end
                    if (pix_cnt_q != PIX_MAX) begin
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    end
                end

                // A held odd byte at line end means the byte count was wrong.
                if (le_c) begin
                    if (pix_cnt_q != PIX_W'(H_SIZE) || phase) begin
                        geom_err_d = 1'b1;
                    end
                    pix_cnt_d = '0;
                    if (line_cnt_q != LINE_MAX) begin
                        line_cnt_d = line_cnt_q + LINE_W'(1);
                    end
                end

                // Uses the _d values so a coincident line end is included.
                if (fe_c) begin
                    if (!geom_err_d && line_cnt_d == LINE_W'(V_SIZE)) begin
                        frame_done_d = 1'b1;
                        frame_err_d  = 1'b0;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                    state_d = ST_WAIT_FS;
                end
            end

            default: state_d = ST_SKIP;
        endcase
    end

    assign bus.cam_w_req  = w_req_q;
    assign bus.cam_w_data = w_data_q;
    assign frame_done     = frame_done_q;
    assign frame_err      = frame_err_q;
    assign overflow       = overflow_q;
    assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Bench for cmos_capture_ctrl with a 4x2 frame and two settle frames.
// The frame driver pushes expected FIFO words into a queue; a negedge
// monitor pops and compares them as cam_w_req fires.
module tb_cmos_capture_ctrl;
    import cmos_capture_ctrl_pkg::*;

    localparam int unsigned H      = 4;
    localparam int unsigned V      = 2;
    localparam int unsigned SKIP   = 2;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned MARGIN = 4;
    localparam logic [10:0] USEDW_HIGH = 11'd1020;

    typedef struct {
        logic [15:0] word;
        bit          mark;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       capture_en;
    logic       frame_done;
    logic       frame_err;
    logic       overflow;
    logic [7:0] frame_cnt;

    cmos_capture_ctrl_if bus_if ();

    cmos_capture_ctrl #(
        .H_SIZE      (H),
        .V_SIZE      (V),
        .SKIP_FRAMES (SKIP),
        .FIFO_DEPTH  (DEPTH),
        .FIFO_MARGIN (MARGIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .capture_en (capture_en),
        .bus        (bus_if),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  done_cnt = 0;
    int  lat_mark = 0;
    bit  prev_req = 1'b0;
    bit  ovf_next = 1'b0;
    sb_t sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            if (frame_done) done_cnt++;
            if (bus_if.cam_w_req) begin
                check_eq("wr_expected", 32'(sb_q.size() != 0), 32'd1);
                check_eq("req_single", 32'(prev_req), 32'd0);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("wr_data", 32'(bus_if.cam_w_data), 32'(e.word));
                    if (e.mark) check_eq("wr_latency", 32'(cyc - lat_mark), 32'd2);
                end
            end
            prev_req = bus_if.cam_w_req;
        end
    end

    // One cycle of drive; usedw is raised for exactly the cycle in which
    // the flagged word is judged by the DUT.
    task automatic tick();
        @(negedge clk);
        bus_if.w_fifo_usedw = ovf_next ? USEDW_HIGH : 11'd0;
        ovf_next = 1'b0;
    endtask

    function automatic logic [15:0] exp_word(input int px, input logic [7:0] hi, input logic [7:0] lo);
`ifdef CMOS_CAPTURE_TEST_PATTERN_EN
        int sw;
        int idx;
        sw  = (H / 8 > 0) ? int'(H / 8) : 1;
        idx = px / sw;
        if (idx > 7) idx = 7;
        return colour_bar(3'(idx));
`else
        return {hi, lo};
`endif
    endfunction

    task automatic drive_frame(input int n_lines, input int n_bytes, input bit cap,
                               input bit en_at_fs, input int ovf_pix, input bit mark_first);
        int         pix;
        logic [7:0] hi;
        logic [7:0] lo;
        sb_t        e;
        hi = 8'h00;
        capture_en = en_at_fs;
        repeat (2) tick();
        bus_if.cmos_vsync = 1'b0;
        repeat (3) tick();
        pix = 0;
        for (int l = 0; l < n_lines; l++) begin
            for (int b = 0; b < n_bytes; b++) begin
                tick();
                bus_if.cmos_href = 1'b1;
                if (mark_first && l == 0 && b < 2) lo = (b == 0) ? 8'hF8 : 8'h00;
                else lo = 8'($urandom_range(0, 255));
                bus_if.cmos_data = lo;
                if (b % 2 == 0) begin
                    hi = lo;
                end else begin
                    if (pix == ovf_pix) ovf_next = 1'b1;
                    if (cap && (b / 2) < int'(H) && l < int'(V) && pix != ovf_pix) begin
                        e.word = exp_word(b / 2, hi, lo);
                        e.mark = mark_first && l == 0 && b == 1;
                        if (e.mark) lat_mark = cyc;
                        sb_q.push_back(e);
                    end
                    pix++;
                end
            end
            tick();
            bus_if.cmos_href = 1'b0;
            tick();
            capture_en = 1'b1;
        end
        repeat (2) tick();
        bus_if.cmos_vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic frame_checks(input int d0, input int exp_done, input logic [7:0] exp_cnt,
                                input logic exp_err, input logic exp_ovf);
        check_eq("frame_done_pulses", 32'(done_cnt - d0), 32'(exp_done));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check_eq("frame_err", 32'(frame_err), 32'(exp_err));
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_w_req"}, 32'(bus_if.cam_w_req), 32'd0);
        check_eq({tag, "_w_data"}, 32'(bus_if.cam_w_data), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
        check_eq({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        int d;
        rst                 = 1'b1;
        capture_en          = 1'b1;
        bus_if.cmos_vsync   = 1'b1;
        bus_if.cmos_href    = 1'b0;
        bus_if.cmos_data    = 8'h00;
        bus_if.w_fifo_usedw = 11'd0;
        repeat (3) @(negedge clk);
        reset_checks("rst");
        rst = 1'b0;

        // Two settle frames: nothing written.
        d = done_cnt;
        drive_frame(2, 8, 1'b0, 1'b1, -1, 1'b0);
        drive_frame(2, 8, 1'b0, 1'b1, -1, 1'b0);
        frame_checks(d, 0, 8'd0, 1'b0, 1'b0);

        // First captured frame, leading pixel F8,00 latency-tagged.
        d = done_cnt;
        drive_frame(2, 8, 1'b1, 1'b1, -1, 1'b1);
        frame_checks(d, 1, 8'd1, 1'b0, 1'b0);

        // Nine-byte lines: four writes each, geometry error, no done.
        d = done_cnt;
        drive_frame(2, 9, 1'b1, 1'b1, -1, 1'b0);
        frame_checks(d, 0, 8'd1, 1'b1, 1'b0);

        // FIFO near full on the third pixel: word dropped, frame still good.
        d = done_cnt;
        drive_frame(2, 8, 1'b1, 1'b1, 2, 1'b0);
        frame_checks(d, 1, 8'd2, 1'b0, 1'b1);

        // Enable low at frame start, raised mid-frame: frame ignored.
        d = done_cnt;
        drive_frame(2, 8, 1'b0, 1'b0, -1, 1'b0);
        frame_checks(d, 0, 8'd2, 1'b0, 1'b1);

        // Next frame captured again, overflow cleared at its start.
        d = done_cnt;
        drive_frame(2, 8, 1'b1, 1'b1, -1, 1'b0);
        frame_checks(d, 1, 8'd3, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a line.
        tick();
        bus_if.cmos_vsync = 1'b0;
        repeat (4) tick();
        bus_if.cmos_href = 1'b1;
        bus_if.cmos_data = 8'h5A;
        #2 rst = 1'b1;
        #1 reset_checks("async_rst");
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            bus_if.cmos_data = 8'($urandom_range(0, 255));
        end
        tick();
        bus_if.cmos_href = 1'b0;
        repeat (3) tick();
        bus_if.cmos_vsync = 1'b1;
        repeat (4) tick();

        // Second settle frame after reset, then capture resumes.
        d = done_cnt;
        drive_frame(2, 8, 1'b0, 1'b1, -1, 1'b0);
        frame_checks(d, 0, 8'd0, 1'b0, 1'b0);
        d = done_cnt;
        drive_frame(2, 8, 1'b1, 1'b1, -1, 1'b0);
        frame_checks(d, 1, 8'd1, 1'b0, 1'b0);

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
